// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent integer clock dividers on clk_hf with per-period ratio updates.
// Each channel produces a registered near-50% clock and a period-start tick.
module clk_div_multi #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic              clk_hf,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] div_wr,
   input  logic [DIV_W-1:0]  div_wdata,
   input  logic              sync_restart,
   output logic [NUM_CH-1:0] div_busy,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W:0]   ONE_X   = (DIV_W+1)'(1);

   logic [DIV_W-1:0]  cnt_q      [NUM_CH];
   logic [DIV_W-1:0]  cnt_d      [NUM_CH];
   logic [DIV_W-1:0]  div_cur_q  [NUM_CH];
   logic [DIV_W-1:0]  div_cur_d  [NUM_CH];
   logic [DIV_W-1:0]  div_pend_q [NUM_CH];
   logic [DIV_W-1:0]  div_pend_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] run_q, run_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] clk_q, clk_d;
   logic [DIV_W-1:0]  wdata_clamped;

   // Ratios below 2 cannot produce a tick/clock pair, so they are raised to 2.
   assign wdata_clamped = (div_wdata < DIV_MIN) ? DIV_MIN : div_wdata;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_d[c]      = cnt_q[c];
         div_cur_d[c]  = div_cur_q[c];
         div_pend_d[c] = div_pend_q[c];
         pend_d[c]     = pend_q[c];
         run_d[c]      = run_q[c];

         if (!ch_en[c]) begin
            cnt_d[c]  = '0;
            run_d[c]  = 1'b0;
            pend_d[c] = 1'b0;
            if (pend_q[c]) div_cur_d[c] = div_pend_q[c];
            if (div_wr[c]) div_cur_d[c] = wdata_clamped;
         end else if (sync_restart || !run_q[c]) begin
            // Period starts fresh here, so a write can take effect at once.
            cnt_d[c]  = '0;
            run_d[c]  = 1'b1;
            pend_d[c] = 1'b0;
            if (pend_q[c]) div_cur_d[c] = div_pend_q[c];
            if (div_wr[c]) div_cur_d[c] = wdata_clamped;
         end else if (cnt_q[c] == div_cur_q[c] - ONE) begin
            cnt_d[c]  = '0;
            pend_d[c] = 1'b0;
            if (pend_q[c]) div_cur_d[c] = div_pend_q[c];
            if (div_wr[c]) begin
               div_pend_d[c] = wdata_clamped;
               pend_d[c]     = 1'b1;
            end
         end else begin
            cnt_d[c] = cnt_q[c] + ONE;
            if (div_wr[c]) begin
               div_pend_d[c] = wdata_clamped;
               pend_d[c]     = 1'b1;
            end
         end

         // Outputs follow the count being entered, using the ratio of that period.
         tick_d[c] = run_d[c] && (cnt_d[c] == '0);
         clk_d[c]  = run_d[c] &&
                     ({1'b0, cnt_d[c]} < (({1'b0, div_cur_d[c]} + ONE_X) >> 1));
      end
   end

   always_ff @(posedge clk_hf) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]      <= '0;
            div_cur_q[c]  <= DIV_RST;
            div_pend_q[c] <= DIV_RST;
         end
         pend_q <= '0;
         run_q  <= '0;
         tick_q <= '0;
         clk_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]      <= cnt_d[c];
            div_cur_q[c]  <= div_cur_d[c];
            div_pend_q[c] <= div_pend_d[c];
         end
         pend_q <= pend_d;
         run_q  <= run_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
      end
   end

   assign div_busy = pend_q;
   assign clk_out  = clk_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi (2 channels, 8-bit ratio).
module tb_clk_div_multi;

   logic       clk_hf = 1'b0;
   logic       reset;
   logic [1:0] ch_en;
   logic [1:0] div_wr;
   logic [7:0] div_wdata;
   logic       sync_restart;
   logic [1:0] div_busy;
   logic [1:0] clk_out;
   logic [1:0] tick;

   clk_div_multi #(.NUM_CH(2), .DIV_W(8), .DEFAULT_DIV(2)) dut (
      .clk_hf      (clk_hf),
      .reset       (reset),
      .ch_en       (ch_en),
      .div_wr      (div_wr),
      .div_wdata   (div_wdata),
      .sync_restart(sync_restart),
      .div_busy    (div_busy),
      .clk_out     (clk_out),
      .tick        (tick)
   );

   always #5 clk_hf = ~clk_hf;

   typedef struct {
      logic       rst;
      logic [1:0] en;
      logic [1:0] wr;
      logic [7:0] wd;
      logic       sr;
   } stim_t;

   typedef struct {
      logic [1:0] t;
      logic [1:0] c;
      logic [1:0] b;
   } exp_t;

   stim_t st[$];
   exp_t  sb[$];
   int    tests = 0;
   int    fails = 0;

   // One entry per edge: inputs sampled at the edge, outputs expected just after it.
   task automatic add(input logic rst, input logic [1:0] en, input logic [1:0] wr,
                      input logic [7:0] wd, input logic sr,
                      input logic [1:0] t, input logic [1:0] c, input logic [1:0] b);
      stim_t s;
      exp_t  e;
      s = '{rst, en, wr, wd, sr};
      e = '{t, c, b};
      st.push_back(s);
      sb.push_back(e);
   endtask

   task automatic test_reset();
      stim_t s;
      exp_t  e;
      int    i = 0;
      add(1'b1, 2'b00, 2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00);
      add(1'b1, 2'b00, 2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00);
      add(1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00);
      while (st.size() > 0) begin
         s = st.pop_front();
         reset = s.rst; ch_en = s.en; div_wr = s.wr; div_wdata = s.wd; sync_restart = s.sr;
         @(posedge clk_hf); #1;
         e = sb.pop_front();
         tests += 3;
         if (tick !== e.t) begin fails++; $display("FAIL reset[%0d] tick=%b expected %b", i, tick, e.t); end
         if (clk_out !== e.c) begin fails++; $display("FAIL reset[%0d] clk_out=%b expected %b", i, clk_out, e.c); end
         if (div_busy !== e.b) begin fails++; $display("FAIL reset[%0d] div_busy=%b expected %b", i, div_busy, e.b); end
         i++;
      end
   endtask

   task automatic test_default();
      stim_t s;
      exp_t  e;
      int    i = 0;
      for (int k = 0; k < 8; k++)
         add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, {1'b0, k % 2 == 0}, {1'b0, k % 2 == 0}, 2'b00);
      while (st.size() > 0) begin
         s = st.pop_front();
         reset = s.rst; ch_en = s.en; div_wr = s.wr; div_wdata = s.wd; sync_restart = s.sr;
         @(posedge clk_hf); #1;
         e = sb.pop_front();
         tests += 3;
         if (tick !== e.t) begin fails++; $display("FAIL default[%0d] tick=%b expected %b", i, tick, e.t); end
         if (clk_out !== e.c) begin fails++; $display("FAIL default[%0d] clk_out=%b expected %b", i, clk_out, e.c); end
         if (div_busy !== e.b) begin fails++; $display("FAIL default[%0d] div_busy=%b expected %b", i, div_busy, e.b); end
         i++;
      end
   endtask

   task automatic test_write5();
      stim_t s;
      exp_t  e;
      int    i = 0;
      add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00);
      add(1'b0, 2'b01, 2'b01, 8'd5, 1'b0, 2'b00, 2'b00, 2'b01);
      for (int n = 0; n < 10; n++)
         add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, {1'b0, n % 5 == 0}, {1'b0, n % 5 < 3}, 2'b00);
      while (st.size() > 0) begin
         s = st.pop_front();
         reset = s.rst; ch_en = s.en; div_wr = s.wr; div_wdata = s.wd; sync_restart = s.sr;
         @(posedge clk_hf); #1;
         e = sb.pop_front();
         tests += 3;
         if (tick !== e.t) begin fails++; $display("FAIL write5[%0d] tick=%b expected %b", i, tick, e.t); end
         if (clk_out !== e.c) begin fails++; $display("FAIL write5[%0d] clk_out=%b expected %b", i, clk_out, e.c); end
         if (div_busy !== e.b) begin fails++; $display("FAIL write5[%0d] div_busy=%b expected %b", i, div_busy, e.b); end
         i++;
      end
   endtask

   task automatic test_clamp();
      stim_t s;
      exp_t  e;
      int    i = 0;
      add(1'b0, 2'b00, 2'b10, 8'd7, 1'b0, 2'b00, 2'b00, 2'b00);
      add(1'b0, 2'b00, 2'b10, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00);
      for (int n = 0; n < 4; n++)
         add(1'b0, 2'b10, 2'b00, 8'd0, 1'b0, {n % 2 == 0, 1'b0}, {n % 2 == 0, 1'b0}, 2'b00);
      add(1'b0, 2'b00, 2'b10, 8'd9, 1'b0, 2'b00, 2'b00, 2'b00);
      add(1'b0, 2'b00, 2'b10, 8'd1, 1'b0, 2'b00, 2'b00, 2'b00);
      for (int n = 0; n < 4; n++)
         add(1'b0, 2'b10, 2'b00, 8'd0, 1'b0, {n % 2 == 0, 1'b0}, {n % 2 == 0, 1'b0}, 2'b00);
      while (st.size() > 0) begin
         s = st.pop_front();
         reset = s.rst; ch_en = s.en; div_wr = s.wr; div_wdata = s.wd; sync_restart = s.sr;
         @(posedge clk_hf); #1;
         e = sb.pop_front();
         tests += 3;
         if (tick !== e.t) begin fails++; $display("FAIL clamp[%0d] tick=%b expected %b", i, tick, e.t); end
         if (clk_out !== e.c) begin fails++; $display("FAIL clamp[%0d] clk_out=%b expected %b", i, clk_out, e.c); end
         if (div_busy !== e.b) begin fails++; $display("FAIL clamp[%0d] div_busy=%b expected %b", i, div_busy, e.b); end
         i++;
      end
   endtask

   task automatic test_last_wins();
      stim_t s;
      exp_t  e;
      int    i = 0;
      add(1'b0, 2'b00, 2'b01, 8'd4, 1'b0, 2'b00, 2'b00, 2'b00);
      add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00);
      add(1'b0, 2'b01, 2'b01, 8'd3, 1'b0, 2'b00, 2'b01, 2'b01);
      add(1'b0, 2'b01, 2'b01, 8'd7, 1'b0, 2'b00, 2'b00, 2'b01);
      add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b01);
      for (int n = 0; n < 14; n++)
         add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, {1'b0, n % 7 == 0}, {1'b0, n % 7 < 4}, 2'b00);
      while (st.size() > 0) begin
         s = st.pop_front();
         reset = s.rst; ch_en = s.en; div_wr = s.wr; div_wdata = s.wd; sync_restart = s.sr;
         @(posedge clk_hf); #1;
         e = sb.pop_front();
         tests += 3;
         if (tick !== e.t) begin fails++; $display("FAIL last_wins[%0d] tick=%b expected %b", i, tick, e.t); end
         if (clk_out !== e.c) begin fails++; $display("FAIL last_wins[%0d] clk_out=%b expected %b", i, clk_out, e.c); end
         if (div_busy !== e.b) begin fails++; $display("FAIL last_wins[%0d] div_busy=%b expected %b", i, div_busy, e.b); end
         i++;
      end
   endtask

   task automatic test_sync_restart();
      stim_t s;
      exp_t  e;
      int    i = 0;
      add(1'b0, 2'b01, 2'b10, 8'd4, 1'b0, 2'b01, 2'b01, 2'b00);
      add(1'b0, 2'b01, 2'b01, 8'd3, 1'b1, 2'b01, 2'b01, 2'b00);
      add(1'b0, 2'b11, 2'b00, 8'd0, 1'b0, 2'b10, 2'b11, 2'b00);
      add(1'b0, 2'b11, 2'b00, 8'd0, 1'b0, 2'b00, 2'b10, 2'b00);
      for (int n = 0; n < 25; n++)
         add(1'b0, 2'b11, 2'b00, 8'd0, n == 0,
             {n % 4 == 0, n % 3 == 0}, {n % 4 < 2, n % 3 < 2}, 2'b00);
      while (st.size() > 0) begin
         s = st.pop_front();
         reset = s.rst; ch_en = s.en; div_wr = s.wr; div_wdata = s.wd; sync_restart = s.sr;
         @(posedge clk_hf); #1;
         e = sb.pop_front();
         tests += 3;
         if (tick !== e.t) begin fails++; $display("FAIL sync[%0d] tick=%b expected %b", i, tick, e.t); end
         if (clk_out !== e.c) begin fails++; $display("FAIL sync[%0d] clk_out=%b expected %b", i, clk_out, e.c); end
         if (div_busy !== e.b) begin fails++; $display("FAIL sync[%0d] div_busy=%b expected %b", i, div_busy, e.b); end
         i++;
      end
   endtask

   task automatic test_reset_mid();
      stim_t s;
      exp_t  e;
      int    i = 0;
      add(1'b0, 2'b00, 2'b01, 8'd6, 1'b0, 2'b00, 2'b00, 2'b00);
      add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00);
      add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, 2'b00, 2'b01, 2'b00);
      add(1'b0, 2'b01, 2'b00, 8'd0, 1'b0, 2'b00, 2'b01, 2'b00);
      add(1'b0, 2'b01, 2'b01, 8'd9, 1'b0, 2'b00, 2'b00, 2'b01);
      add(1'b1, 2'b01, 2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00);
      for (int n = 0; n < 4; n++)
         add(1'b0, 2'b11, 2'b00, 8'd0, 1'b0,
             (n % 2 == 0) ? 2'b11 : 2'b00, (n % 2 == 0) ? 2'b11 : 2'b00, 2'b00);
      while (st.size() > 0) begin
         s = st.pop_front();
         reset = s.rst; ch_en = s.en; div_wr = s.wr; div_wdata = s.wd; sync_restart = s.sr;
         @(posedge clk_hf); #1;
         e = sb.pop_front();
         tests += 3;
         if (tick !== e.t) begin fails++; $display("FAIL reset_mid[%0d] tick=%b expected %b", i, tick, e.t); end
         if (clk_out !== e.c) begin fails++; $display("FAIL reset_mid[%0d] clk_out=%b expected %b", i, clk_out, e.c); end
         if (div_busy !== e.b) begin fails++; $display("FAIL reset_mid[%0d] div_busy=%b expected %b", i, div_busy, e.b); end
         i++;
      end
   endtask

   initial begin
      reset        = 1'b1;
      ch_en        = 2'b00;
      div_wr       = 2'b00;
      div_wdata    = 8'd0;
      sync_restart = 1'b0;
      test_reset();
      test_default();
      test_write5();
      test_clamp();
      test_last_wins();
      test_sync_restart();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
